alu_operand_sequencer: RTL

Command-side driver for the 8-bit combinational ALU. It accepts accumulator micro-ops over a valid/ready command channel and drives registered operands onto the ALU inputs. It captures the selected ALU result (sum, AND or zero-compare) and returns it over a valid/ready response channel. It sits between the instruction decoder and the ALU and owns the 8-bit accumulator.

---
 rtl/alu_operand_sequencer.sv | 80 ++++++++
 1 files changed

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: drives registered operands to an 8-bit ALU and returns the selected result over valid/ready, optional rsp_carry via ALU_SEQ_CARRY_EN
module alu_operand_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_operand,
  output logic [7:0] alu_x,
  output logic [7:0] alu_y,
  input  logic [7:0] alu_sum,
  input  logic [7:0] alu_and,
  input  logic [7:0] alu_cmp,
  output logic [7:0] acc,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_zero
`ifdef ALU_SEQ_CARRY_EN
  ,
  output logic       rsp_carry
`endif
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic [1:0] OP_ADD = 2'b00, OP_AND = 2'b01, OP_CMPZ = 2'b10;
  state_t state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [7:0] y_q, y_d, acc_q, acc_d, data_q, data_d, result;
  logic zero_q, zero_d, accept, exec;
`ifdef ALU_SEQ_CARRY_EN
  logic carry_q, carry_d;
`endif
  always_comb begin
    accept  = state_q == IDLE && cmd_valid;
    exec    = state_q == EXEC;
    state_d = state_q == IDLE ? (cmd_valid ? EXEC : IDLE) :
              state_q == EXEC ? RESP : (rsp_ready ? IDLE : RESP);
    result  = op_q == OP_ADD ? alu_sum : op_q == OP_AND ? alu_and : op_q == OP_CMPZ ? alu_cmp : y_q;
    op_d    = accept ? cmd_op : op_q;
    y_d     = accept ? cmd_operand : y_q;
    acc_d   = exec && op_q != OP_CMPZ ? result : acc_q;
    data_d  = exec ? result : data_q;
    zero_d  = exec ? result == 8'h00 : zero_q;
`ifdef ALU_SEQ_CARRY_EN
    carry_d = exec ? op_q == OP_ADD && alu_sum < acc_q : carry_q;
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= 2'b00;
      y_q     <= 8'h00;
      acc_q   <= 8'h00;
      data_q  <= 8'h00;
      zero_q  <= 1'b0;
`ifdef ALU_SEQ_CARRY_EN
      carry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
`ifdef ALU_SEQ_CARRY_EN
      carry_q <= carry_d;
`endif
    end
  assign cmd_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign alu_x     = acc_q;
  assign alu_y     = y_q;
  assign acc       = acc_q;
  assign rsp_data  = data_q;
  assign rsp_zero  = zero_q;
`ifdef ALU_SEQ_CARRY_EN
  assign rsp_carry = carry_q;
`endif
endmodule
